// File: rtl/text_vram_axi_slave.sv
// text_vram_axi_slave
//   AXI4-Lite slave that owns the 601-word text-mode video RAM. Words 0..599
//   hold 80x30 glyph bytes, four per word. Byte 0 is the leftmost glyph, and
//   bit 7 of each byte is its invert flag. Word 600 is the colour control
//   register. vga_ram is registered and is read combinationally by the
//   colour mapper.
//
//   Ports:
//     Clk, Reset               clock; asynchronous active-high reset
//     aw*/w*/b*                AXI4-Lite write channels (byte strobes honoured)
//     ar*/r*                   AXI4-Lite read channels
//     vga_ram[NUM_REGS]        registered RAM contents for the colour mapper
//
//   Build option VRAM_READBACK_EN:
//     defined   - reads return the stored word.
//     undefined - reads still handshake with the same timing, but always
//                 return 0 with SLVERR, and no read mux is built.
module text_vram_axi_slave #(
  parameter int C_ADDR_WIDTH = 12,
  parameter int NUM_REGS     = 601
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [C_ADDR_WIDTH-1:0] awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [C_ADDR_WIDTH-1:0] araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [31:0]             vga_ram [NUM_REGS]
);
  localparam int              IDX_W  = C_ADDR_WIDTH - 2;
  localparam logic [IDX_W:0]  LIMIT  = NUM_REGS[IDX_W:0];
  localparam logic [1:0]      OKAY   = 2'b00;
  localparam logic [1:0]      SLVERR = 2'b10;

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
  wstate_t          wstate;
  logic             aw_held, w_held;
  logic [IDX_W-1:0] aw_idx;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             aw_hs, w_hs, wr_in_range;
  logic             aw_held_n, w_held_n, bvalid_n;
  logic             unused_aw_lsbs;

  assign aw_hs          = awvalid & awready;
  assign w_hs           = wvalid & wready;
  assign wr_in_range    = {1'b0, aw_idx} < LIMIT;
  assign unused_aw_lsbs = ^awaddr[1:0];

  // The ready outputs are registered. They are computed from next-state
  // values so that they drop on the same edge that fills a holding register
  // or raises bvalid.
  always_comb begin
    aw_held_n = aw_held | aw_hs;
    w_held_n  = w_held | w_hs;
    bvalid_n  = bvalid;
    if (wstate == W_COMMIT) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      bvalid_n  = 1'b1;
    end else if (bvalid & bready) begin
      bvalid_n  = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wstate  <= W_IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      for (int i = 0; i < NUM_REGS; i++) vga_ram[i] <= '0;
    end else begin
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      bvalid  <= bvalid_n;
      awready <= ~aw_held_n & ~bvalid_n;
      wready  <= ~w_held_n & ~bvalid_n;
      if (aw_hs) aw_idx <= awaddr[C_ADDR_WIDTH-1:2];
      if (w_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      case (wstate)
        W_IDLE:   if (aw_held_n & w_held_n) wstate <= W_COMMIT;
        W_COMMIT: begin
          wstate <= W_RESP;
          bresp  <= wr_in_range ? OKAY : SLVERR;
          if (wr_in_range)
            for (int i = 0; i < 4; i++)
              if (wstrb_q[i]) vga_ram[aw_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
        W_RESP:   if (bvalid & bready) wstate <= W_IDLE;
        default:  wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  rstate_t     rstate;
  logic [31:0] rd_word;
  logic [1:0]  rd_resp;
  logic        unused_ar;

`ifdef VRAM_READBACK_EN
  logic [IDX_W-1:0] ar_idx;
  logic             rd_in_range;
  assign ar_idx      = araddr[C_ADDR_WIDTH-1:2];
  assign rd_in_range = {1'b0, ar_idx} < LIMIT;
  assign rd_word     = rd_in_range ? vga_ram[ar_idx] : 32'h0;
  assign rd_resp     = rd_in_range ? OKAY : SLVERR;
  assign unused_ar   = ^araddr[1:0];
`else
  assign rd_word     = 32'h0;
  assign rd_resp     = SLVERR;
  assign unused_ar   = ^araddr;
`endif

  // rdata is sampled with non-blocking semantics, so a read that lands on the
  // same edge as a commit to that word returns the pre-write value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rstate  <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          arready <= 1'b1;
          if (arvalid & arready) begin
            rstate  <= R_DATA;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_word;
            rresp   <= rd_resp;
          end
        end
        R_DATA: if (rready) begin
          rstate  <= R_IDLE;
          rvalid  <= 1'b0;
          arready <= 1'b1;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_vram_axi_slave.sv
// Testbench for text_vram_axi_slave. Expected B and R responses are pushed to
// scoreboard queues when a transaction is issued and popped when the DUT
// presents them. A bench-side RAM model tracks the expected contents.
module tb_text_vram_axi_slave;
  localparam int NUM_REGS = 601;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] vga_ram [NUM_REGS];

  typedef struct packed { logic [31:0] data; logic [1:0] resp; } exp_t;
  exp_t        b_q[$];
  exp_t        r_q[$];
  logic [31:0] model [NUM_REGS];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 Clk = ~Clk;

  text_vram_axi_slave #(.C_ADDR_WIDTH(12), .NUM_REGS(NUM_REGS)) dut (
    .Clk(Clk), .Reset(Reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .vga_ram(vga_ram)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
    $fatal(1);
  end

  task automatic test_reset();
    bit bad;
    #1 Reset = 1'b1;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_valids got %b want 00000", {awready, wready, arready, bvalid, rvalid});
    end
    n_cmp++;
    if (bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_payload got bresp=%b rresp=%b rdata=%h want 0", bresp, rresp, rdata);
    end
    bad = 0;
    for (int i = 0; i < NUM_REGS; i++) if (vga_ram[i] !== 32'h0) bad = 1;
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL reset_ram got nonzero word want all zero"); end
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
    Reset = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if ({awready, wready, arready} !== 3'b111) begin
      n_err++;
      $display("FAIL ready_after_reset got %b want 111", {awready, wready, arready});
    end
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int bhold, input bit abort);
    int          idx, cyc;
    bit          inr, aw_done, w_done, aw_go, w_go, bad;
    logic [31:0] old_w, new_w;
    logic [1:0]  resp0;
    exp_t        e;
    idx = int'(addr[11:2]);
    inr = idx < NUM_REGS;
    old_w = inr ? model[idx] : 32'h0;
    new_w = old_w;
    for (int i = 0; i < 4; i++) if (strb[i]) new_w[8*i +: 8] = data[8*i +: 8];
    e.data = new_w;
    e.resp = inr ? 2'b00 : 2'b10;
    b_q.push_back(e);
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge Clk);
      n_cmp++;
      if (bvalid !== 1'b0) begin n_err++; $display("FAIL b_before_handshake got bvalid=%b want 0", bvalid); end
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid  = !w_done && cyc >= w_dly;
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      @(posedge Clk);
      if (aw_go) aw_done = 1;
      if (w_go) w_done = 1;
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      n_cmp++; n_err++;
      $display("FAIL aw_w_timeout got aw=%0d w=%0d want both accepted", aw_done, w_done);
      void'(b_q.pop_back());
      @(negedge Clk); awvalid = 0; wvalid = 0;
      return;
    end
    @(negedge Clk);
    awvalid = 0; wvalid = 0;
    n_cmp++;
    if (bvalid !== 1'b0 || (inr && vga_ram[idx] !== old_w)) begin
      n_err++;
      $display("FAIL commit_early got bvalid=%b ram=%h want 0 / %h", bvalid, inr ? vga_ram[idx] : 32'h0, old_w);
    end
    @(negedge Clk);
    n_cmp++;
    if (bvalid !== 1'b1) begin n_err++; $display("FAIL bvalid_rise got %b want 1", bvalid); end
    if (inr) begin
      n_cmp++;
      if (vga_ram[idx] !== new_w) begin
        n_err++;
        $display("FAIL ram_update word %0d got %h want %h", idx, vga_ram[idx], new_w);
      end
      model[idx] = new_w;
    end
    if (abort) begin
      #2 Reset = 1'b1;
      #1;
      n_cmp++;
      if (bvalid !== 1'b0) begin n_err++; $display("FAIL reset_mid_bvalid got %b want 0", bvalid); end
      bad = 0;
      for (int i = 0; i < NUM_REGS; i++) if (vga_ram[i] !== 32'h0) bad = 1;
      n_cmp++;
      if (bad) begin n_err++; $display("FAIL reset_mid_ram got nonzero word want all zero"); end
      b_q.delete();
      r_q.delete();
      for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      return;
    end
    resp0 = bresp;
    for (int k = 0; k < bhold; k++) begin
      n_cmp++;
      if (bvalid !== 1'b1 || bresp !== resp0 || awready !== 1'b0 || wready !== 1'b0) begin
        n_err++;
        $display("FAIL b_hold got bvalid=%b bresp=%b awready=%b wready=%b want 1 %b 0 0",
                 bvalid, bresp, awready, wready, resp0);
      end
      @(negedge Clk);
    end
    bready = 1'b1;
    e = b_q.pop_front();
    n_cmp++;
    if (bvalid !== 1'b1 || bresp !== e.resp) begin
      n_err++;
      $display("FAIL bresp got bvalid=%b bresp=%b want 1 %b", bvalid, bresp, e.resp);
    end
    @(posedge Clk);
    @(negedge Clk);
    bready = 1'b0;
    n_cmp++;
    if (bvalid !== 1'b0 || awready !== 1'b1) begin
      n_err++;
      $display("FAIL b_single got bvalid=%b awready=%b want 0 1", bvalid, awready);
    end
  endtask

  task automatic do_read(input logic [11:0] addr, input int rhold);
    int          idx, cyc;
    bit          inr, go;
    logic [31:0] d0;
    exp_t        e;
    idx = int'(addr[11:2]);
    inr = idx < NUM_REGS;
`ifdef VRAM_READBACK_EN
    e.data = inr ? model[idx] : 32'h0;
    e.resp = inr ? 2'b00 : 2'b10;
`else
    e.data = 32'h0;
    e.resp = 2'b10;
`endif
    r_q.push_back(e);
    go = 0; cyc = 0;
    while (!go && cyc < 40) begin
      @(negedge Clk);
      araddr = addr; arvalid = 1'b1;
      go = arready;
      @(posedge Clk);
      cyc++;
    end
    @(negedge Clk);
    arvalid = 1'b0;
    if (!go) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout got no arready want handshake");
      void'(r_q.pop_back());
      return;
    end
    n_cmp++;
    if (rvalid !== 1'b1) begin n_err++; $display("FAIL r_latency got rvalid=%b want 1", rvalid); end
    d0 = rdata;
    for (int k = 0; k < rhold; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (rvalid !== 1'b1 || rdata !== d0) begin
        n_err++;
        $display("FAIL r_hold got rvalid=%b rdata=%h want 1 %h", rvalid, rdata, d0);
      end
    end
    rready = 1'b1;
    e = r_q.pop_front();
    n_cmp++;
    if (rdata !== e.data || rresp !== e.resp) begin
      n_err++;
      $display("FAIL rdata addr %h got %h/%b want %h/%b", addr, rdata, rresp, e.data, e.resp);
    end
    @(posedge Clk);
    @(negedge Clk);
    rready = 1'b0;
    n_cmp++;
    if (rvalid !== 1'b0) begin n_err++; $display("FAIL r_single got rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_write_same_cycle();
    do_write(12'h000, 32'h44434241, 4'hF, 0, 0, 0, 0);
    n_cmp++;
    if (vga_ram[0] !== 32'h44434241) begin
      n_err++;
      $display("FAIL word0 got %h want 44434241", vga_ram[0]);
    end
    do_read(12'h000, 0);
  endtask

  task automatic test_w_before_aw();
    do_write(12'h960, 32'h01FE0000, 4'hF, 3, 0, 0, 0);
    n_cmp++;
    if (vga_ram[600] !== 32'h01FE0000) begin
      n_err++;
      $display("FAIL word600 got %h want 01FE0000", vga_ram[600]);
    end
    do_read(12'h960, 0);
  endtask

  task automatic test_strobes();
    do_write(12'h014, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0);
    do_write(12'h017, 32'h11223344, 4'b0101, 0, 2, 0, 0);
    n_cmp++;
    if (vga_ram[5] !== 32'hAA22CC44) begin
      n_err++;
      $display("FAIL strobe_merge got %h want AA22CC44", vga_ram[5]);
    end
    do_write(12'h014, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0);
    n_cmp++;
    if (vga_ram[5] !== 32'hAA22CC44) begin
      n_err++;
      $display("FAIL zero_strobe got %h want AA22CC44", vga_ram[5]);
    end
    do_read(12'h015, 2);
  endtask

  task automatic test_out_of_range();
    bit bad;
    do_write(12'h964, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < NUM_REGS; i++) if (vga_ram[i] !== model[i]) bad = 1;
    n_cmp++;
    if (bad) begin n_err++; $display("FAIL oor_write_ram got changed RAM want unchanged"); end
    do_read(12'hFFC, 0);
  endtask

  task automatic test_back_to_back_backpressure();
    fork
      do_write(12'h020, 32'h12345678, 4'hF, 1, 0, 10, 0);
      begin
        repeat (3) @(negedge Clk);
        do_read(12'h000, 1);
        do_read(12'h960, 0);
      end
    join
  endtask

  task automatic test_reset_mid();
    do_write(12'h004, 32'hCAFEBABE, 4'hF, 0, 0, 0, 1);
    do_write(12'h008, 32'h0BADF00D, 4'hF, 0, 1, 0, 0);
    do_read(12'h004, 0);
    do_read(12'h008, 0);
  endtask

  initial begin
    test_reset();
    test_write_same_cycle();
    test_w_before_aw();
    test_strobes();
    test_out_of_range();
    test_back_to_back_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/text_vram_axi_slave.md
# text_vram_axi_slave

AXI4-Lite slave that owns the 601-word text-mode video RAM and lets the MicroBlaze write and read it. Words 0–599 hold 80×30 characters, four per word. Little-endian byte order: byte 0 is the leftmost glyph, and bit 7 of each byte is the invert flag. Word 600 is the colour control register. The block sits between the AXI interconnect and the colour mapper. It drives the `vga_ram` array, which the mapper reads combinationally every pixel.

## Interface
Parameters:
- `C_ADDR_WIDTH`, default 12: byte-address width. Word index is `addr[11:2]`.
- `NUM_REGS`, default 601: number of implemented 32-bit words.

Ports:
- `Clk`  in  1: system clock (AXI ACLK).
- `Reset`  in  1: asynchronous, active-high reset.
- `awaddr`  in  C_ADDR_WIDTH: write address.
- `awvalid` in 1; `awready` out 1: write-address handshake.
- `wdata`  in  32: write data.
- `wstrb`  in  4: byte-lane enables.
- `wvalid` in 1; `wready` out 1: write-data handshake.
- `bresp`  out  2: write response. 2'b00 is OKAY, 2'b10 is SLVERR.
- `bvalid` out 1; `bready` in 1: write-response handshake.
- `araddr`  in  C_ADDR_WIDTH: read address.
- `arvalid` in 1; `arready` out 1: read-address handshake.
- `rdata`  out  32: read data.
- `rresp`  out  2: read response.
- `rvalid` out 1; `rready` in 1: read-data handshake.
- `vga_ram`  out  32 × NUM_REGS: unpacked array, registered, continuously visible to the colour mapper.

## Operation
- Write path:
  - AW and W are captured independently into holding registers, in either order or in the same cycle.
  - `awready` is high only when no address is held and `bvalid` is 0; `wready` follows the same rule for data.
  - Once both are held, the write commits on the next edge. The held addresses and data clear on that edge.
- Byte strobes: each lane `i` with `wstrb[i]` set updates `vga_ram[idx][8i+7:8i]`; other lanes keep their value. `wstrb` = 0 completes with OKAY and changes nothing.
- Out-of-range access (word index ≥ NUM_REGS):
  - Write: no RAM change, `bresp` = SLVERR.
  - Read: `rdata` = 0, `rresp` = SLVERR.
- Address bits [1:0] are ignored.
- Write FSM states:
  - `W_IDLE` → `W_COMMIT` when both AW and W are held.
  - `W_COMMIT` → `W_RESP` after one cycle; the RAM update happens here, and `bvalid` rises on the same edge.
  - `W_RESP` → `W_IDLE` on `bvalid & bready`.
- Read FSM states:
  - `R_IDLE`, with `arready` = 1 → `R_DATA` on `arvalid`. `rdata` and `rresp` are loaded on that edge.
  - `R_DATA` → `R_IDLE` on `rready`.
- Read and write channels run concurrently.
- Control word 600 has no special write semantics; the colour mapper interprets it.

## Timing
- Reset values:
  - all `vga_ram` words 0, so the screen shows black on black;
  - `awready`, `wready`, `arready`, `bvalid`, `rvalid` all 0;
  - `bresp`, `rresp`, `rdata` all 0.
- The ready outputs are registered. They first go high on the first `Clk` edge after `Reset` deasserts.
- Write latency:
  - the last of the AW/W handshakes occurs at edge N;
  - `vga_ram` updates and `bvalid` rises at edge N+1;
  - new AW/W are accepted no earlier than the edge after the B handshake.
- Read latency: AR handshake at edge N gives `rvalid`/`rdata` valid after edge N. `rdata` is held stable until `rready`.
- A read whose data is sampled on the same edge as a write commit to the same word returns the pre-write value.
- `bvalid`/`rvalid` stay high with a stable payload until their ready input is sampled high. The block never drops a valid without a handshake.
- Reset mid-transaction:
  - pending AW/W holds, B responses and R responses are discarded without handshakes;
  - RAM returns to all-zero.

## Configuration
- `VRAM_READBACK_EN`:
  - Defined: read channel returns the stored word as described above.
  - Undefined: no read mux is synthesised. Reads still handshake with identical timing but return `rdata` = 0 and `rresp` = SLVERR for every address. The write path is unchanged.

## Test plan
- Reset, then write `awaddr`=0x000, `wdata`=0x44434241, `wstrb`=4'hF, with AW and W in the same cycle → `vga_ram[0]`=0x44434241 one edge after the handshake, `bresp`=00. A readback of 0x000 returns 0x44434241 (with `VRAM_READBACK_EN`).
- W sent 3 cycles before AW, to `awaddr`=0x960 (word 600), `wdata`=0x01FE0000 → no commit until AW arrives, then `vga_ram[600]`=0x01FE0000, `bvalid` for one handshake only.
- `vga_ram[5]`=0xAABBCCDD, then write 0x11223344 with `wstrb`=4'b0101 → `vga_ram[5]`=0xAA22CC44.
- Write to `awaddr`=0x964 (word 601) → `bresp`=SLVERR, all RAM unchanged. Read of 0xFFC → `rdata`=0, `rresp`=SLVERR.
- Hold `bready` low for 10 cycles → `bvalid`/`bresp` stable, `awready`=`wready`=0 throughout. Concurrent reads still complete.
- Assert `Reset` while `bvalid`=1 → `bvalid`=0 immediately and all RAM words 0. After release, the next write completes normally.
